ascii_adder_seq: RTL and testbench

//  Sequencer for the 2-digit ASCII adder datapath (operands AD/AU, BD/BU; results YC/YD/YU).
//  - Accepts a serial stream of 4 ASCII digit characters and loads them into the adder operand registers.
//  - Waits for the combinational adder to settle, then captures its result.
//  - Streams the result out as 3 ASCII characters: carry, tens, units.
//  - Sits between a byte-serial front end (UART/keypad) and the adder.

---
 rtl/ascii_adder_pkg.sv | 34 +++
 rtl/ascii_digit_chk.sv | 12 +
 rtl/ascii_adder_seq.sv | 138 +++++++++++++
 tb/tb_ascii_adder_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_adder_pkg.sv
// Shared types and constants for the ASCII adder sequencer.
// Build option: ZERO_SUPPRESS_EN drops a leading '0' carry character.
package ascii_adder_pkg;

  localparam logic [6:0] ASCII_ZERO = 7'h30;
  localparam logic [6:0] ASCII_NINE = 7'h39;

  typedef enum logic [1:0] {
    RX     = 2'd0,
    SETTLE = 2'd1,
    TX     = 2'd2
  } state_t;

  localparam logic [1:0] TX_C = 2'd0;
  localparam logic [1:0] TX_D = 2'd1;
  localparam logic [1:0] TX_U = 2'd2;

  function automatic logic [6:0] sel_char(
    input logic [1:0] i,
    input logic [6:0] c,
    input logic [6:0] d,
    input logic [6:0] u
  );
    logic [6:0] r;
    r = u;
    unique case (i)
      TX_C:    r = c;
      TX_D:    r = d;
      default: r = u;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ascii_digit_chk.sv
// Combinational ASCII decimal digit detector.
// Flags characters '0'..'9'.
module ascii_digit_chk
  import ascii_adder_pkg::*;
(
  input  logic [6:0] ch,
  output logic       is_digit
);

  assign is_digit = (ch >= ASCII_ZERO) && (ch <= ASCII_NINE);

endmodule

// File: rtl/ascii_adder_seq.sv
// Sequencer: collects four ASCII digits, waits for the adder, streams result.
// Build option: ZERO_SUPPRESS_EN skips a '0' carry character on output.
module ascii_adder_seq
  import ascii_adder_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] in_data,
  output logic [6:0] op_ad,
  output logic [6:0] op_au,
  output logic [6:0] op_bd,
  output logic [6:0] op_bu,
  input  logic [6:0] res_yc,
  input  logic [6:0] res_yd,
  input  logic [6:0] res_yu,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_data,
  output logic       busy,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [1:0]       idx;
  logic [1:0]       tx_idx;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       buf_ad;
  logic [6:0]       buf_au;
  logic [6:0]       buf_bd;
  logic [6:0]       rs_c;
  logic [6:0]       rs_d;
  logic [6:0]       rs_u;
  logic             in_dig;
  logic [1:0]       tx_first;
  logic [1:0]       tx_nxt;

  ascii_digit_chk u_chk (
    .ch       (in_data),
    .is_digit (in_dig)
  );

  assign in_ready = (state == RX);
  assign tx_nxt   = tx_idx + 2'd1;

`ifdef ZERO_SUPPRESS_EN
  assign tx_first = (res_yc == ASCII_ZERO) ? TX_D : TX_C;
`else
  assign tx_first = TX_C;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX;
      idx       <= 2'd0;
      tx_idx    <= TX_C;
      cnt       <= '0;
      buf_ad    <= ASCII_ZERO;
      buf_au    <= ASCII_ZERO;
      buf_bd    <= ASCII_ZERO;
      op_ad     <= ASCII_ZERO;
      op_au     <= ASCII_ZERO;
      op_bd     <= ASCII_ZERO;
      op_bu     <= ASCII_ZERO;
      rs_c      <= ASCII_ZERO;
      rs_d      <= ASCII_ZERO;
      rs_u      <= ASCII_ZERO;
      out_valid <= 1'b0;
      out_data  <= ASCII_ZERO;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        RX: begin
          if (in_valid) begin
            if (!in_dig) begin
              err <= 1'b1;
              idx <= 2'd0;
            end else begin
              idx <= idx + 2'd1;
              unique case (idx)
                2'd0: buf_ad <= in_data;
                2'd1: buf_au <= in_data;
                2'd2: buf_bd <= in_data;
                2'd3: begin
                  op_ad <= buf_ad;
                  op_au <= buf_au;
                  op_bd <= buf_bd;
                  op_bu <= in_data;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SETTLE;
                end
              endcase
            end
          end
        end
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            rs_c   <= res_yc;
            rs_d   <= res_yd;
            rs_u   <= res_yu;
            tx_idx <= tx_first;
            state  <= TX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX: begin
          // First TX cycle only presents the character; later ones advance.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= sel_char(tx_idx, rs_c, rs_d, rs_u);
          end else if (out_ready) begin
            if (tx_idx == TX_U) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              idx       <= 2'd0;
              state     <= RX;
            end else begin
              tx_idx   <= tx_nxt;
              out_data <= sel_char(tx_nxt, rs_c, rs_d, rs_u);
            end
          end
        end
        default: state <= RX;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_adder_seq.sv
// Self-checking bench for ascii_adder_seq with a behavioural adder.
// Honours ZERO_SUPPRESS_EN in its reference model.
module tb_ascii_adder_seq;
  import ascii_adder_pkg::*;

  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_data;
  logic [6:0] op_ad, op_au, op_bd, op_bu;
  logic [6:0] res_yc, res_yd, res_yu;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic       busy;
  logic       err;
  logic       out_dig;

  int n_pass   = 0;
  int n_checks = 0;

  logic [6:0] exp_q[$];
  logic [6:0] got_q[$];

  always #5 clk = ~clk;

  ascii_adder_seq #(.SETTLE_CYCLES(SC), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .op_ad     (op_ad),
    .op_au     (op_au),
    .op_bd     (op_bd),
    .op_bu     (op_bu),
    .res_yc    (res_yc),
    .res_yd    (res_yd),
    .res_yu    (res_yu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .err       (err)
  );

  ascii_digit_chk u_out_chk (
    .ch       (out_data),
    .is_digit (out_dig)
  );

  // Stand-in for the external 2-digit adder.
  always_comb begin
    int s;
    s = (int'(op_ad) - 48) * 10 + (int'(op_au) - 48)
      + (int'(op_bd) - 48) * 10 + (int'(op_bu) - 48);
    res_yc = 7'(48 + s / 100);
    res_yd = 7'(48 + (s / 10) % 10);
    res_yu = 7'(48 + s % 10);
  end

  function automatic void fill_exp(input int a, input int b);
    int s;
    s = a + b;
    exp_q.delete();
`ifdef ZERO_SUPPRESS_EN
    if (s >= 100) exp_q.push_back(7'(48 + s / 100));
`else
    exp_q.push_back(7'(48 + s / 100));
`endif
    exp_q.push_back(7'(48 + (s / 10) % 10));
    exp_q.push_back(7'(48 + s % 10));
  endfunction

  function automatic int pack(input logic [6:0] q[$]);
    int v;
    v = 0;
    foreach (q[i]) v = v * 256 + int'(q[i]);
    return v;
  endfunction

  task automatic send_char(input logic [6:0] c);
    int t;
    in_valid = 1'b1;
    in_data  = c;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    if (!in_ready) $display("FAIL send_timeout ready=%b want 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pair(input int a, input int b);
    send_char(7'(48 + a / 10));
    send_char(7'(48 + a % 10));
    send_char(7'(48 + b / 10));
    send_char(7'(48 + b % 10));
  endtask

  task automatic collect(input int n, input bit rnd);
    int t;
    got_q.delete();
    t = 0;
    while (got_q.size() < n && t < 200) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        n_checks++;
        if (out_dig !== 1'b1)
          $display("FAIL out_digit got=%h want digit", out_data);
        else n_pass++;
      end
      @(posedge clk); #1;
      t++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 7'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({op_ad, op_au, op_bd, op_bu} !== {4{7'h30}})
      $display("FAIL rst_ops got=%h want %h", {op_ad, op_au, op_bd, op_bu}, {4{7'h30}});
    else n_pass++;
    n_checks++;
    if ({out_valid, out_data, busy, err, in_ready} !== {1'b0, 7'h30, 1'b0, 1'b0, 1'b1})
      $display("FAIL rst_ctrl got=%b want %b", {out_valid, out_data, busy, err, in_ready},
               {1'b0, 7'h30, 1'b0, 1'b0, 1'b1});
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send_pair(12, 34);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy got=%b want 1", busy);
    else n_pass++;
    n_checks++;
    if ({op_ad, op_au, op_bd, op_bu} !== {7'h31, 7'h32, 7'h33, 7'h34})
      $display("FAIL basic_ops got=%h want %h", {op_ad, op_au, op_bd, op_bu},
               {7'h31, 7'h32, 7'h33, 7'h34});
    else n_pass++;
    fill_exp(12, 34);
    collect(exp_q.size(), 1'b0);
    n_checks++;
    if (pack(got_q) !== pack(exp_q))
      $display("FAIL basic_seq got=%h want %h", pack(got_q), pack(exp_q));
    else n_pass++;
    n_checks++;
    if ({busy, out_valid, in_ready} !== 3'b001)
      $display("FAIL basic_idle got=%b want 001", {busy, out_valid, in_ready});
    else n_pass++;
  endtask

  task automatic test_max();
    int lat;
    send_pair(99, 99);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat !== SC + 1) $display("FAIL max_latency got=%0d want %0d", lat, SC + 1);
    else n_pass++;
    fill_exp(99, 99);
    collect(exp_q.size(), 1'b0);
    n_checks++;
    if (pack(got_q) !== pack(exp_q))
      $display("FAIL max_seq got=%h want %h", pack(got_q), pack(exp_q));
    else n_pass++;
  endtask

  task automatic test_error();
    logic [27:0] ops_before;
    ops_before = {op_ad, op_au, op_bd, op_bu};
    send_char(7'h31);
    send_char(7'h32);
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_idle got=%b want 0", err);
    else n_pass++;
    send_char(7'h41);
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_pulse got=%b want 1", err);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_width got=%b want 0", err);
    else n_pass++;
    n_checks++;
    if ({op_ad, op_au, op_bd, op_bu} !== ops_before)
      $display("FAIL err_ops got=%h want %h", {op_ad, op_au, op_bd, op_bu}, ops_before);
    else n_pass++;
    send_pair(5, 7);
    fill_exp(5, 7);
    collect(exp_q.size(), 1'b0);
    n_checks++;
    if (pack(got_q) !== pack(exp_q))
      $display("FAIL err_seq got=%h want %h", pack(got_q), pack(exp_q));
    else n_pass++;
  endtask

  task automatic test_stall();
    int t;
    out_ready = 1'b0;
    send_pair(12, 34);
    fill_exp(12, 34);
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = 7'h39;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, out_data, in_ready, busy} !== {1'b1, exp_q[0], 1'b0, 1'b1})
        $display("FAIL stall_hold cyc=%0d got=%b want %b", i,
                 {out_valid, out_data, in_ready, busy}, {1'b1, exp_q[0], 1'b0, 1'b1});
      else n_pass++;
    end
    in_valid = 1'b0;
    collect(exp_q.size(), 1'b0);
    n_checks++;
    if (pack(got_q) !== pack(exp_q))
      $display("FAIL stall_seq got=%h want %h", pack(got_q), pack(exp_q));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    send_char(7'h31);
    send_char(7'h32);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({op_ad, op_au, op_bd, op_bu} !== {4{7'h30}})
      $display("FAIL rmid_ops got=%h want %h", {op_ad, op_au, op_bd, op_bu}, {4{7'h30}});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    send_pair(45, 54);
    fill_exp(45, 54);
    collect(exp_q.size(), 1'b0);
    n_checks++;
    if (pack(got_q) !== pack(exp_q))
      $display("FAIL rmid_seq got=%h want %h", pack(got_q), pack(exp_q));
    else n_pass++;
  endtask

  task automatic test_reset_tx();
    send_pair(56, 67);
    collect(1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b001)
      $display("FAIL rtx_async got=%b want 001", {out_valid, busy, in_ready});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    send_pair(31, 8);
    fill_exp(31, 8);
    collect(exp_q.size(), 1'b0);
    n_checks++;
    if (pack(got_q) !== pack(exp_q))
      $display("FAIL rtx_seq got=%h want %h", pack(got_q), pack(exp_q));
    else n_pass++;
  endtask

  task automatic test_random();
    int a, b;
    for (int k = 0; k < 20; k++) begin
      a = int'($urandom_range(0, 99));
      b = int'($urandom_range(0, 99));
      send_pair(a, b);
      fill_exp(a, b);
      collect(exp_q.size(), 1'b1);
      n_checks++;
      if (pack(got_q) !== pack(exp_q))
        $display("FAIL rand_seq a=%0d b=%0d got=%h want %h", a, b, pack(got_q), pack(exp_q));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_error();
    test_stall();
    test_reset_mid();
    test_reset_tx();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
